// File: rtl/an_io_phdet_pkg.sv
// Shared types and default parameters for the phase-detector vote filter.
package an_io_phdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_SETTLE = 2'd3
  } phdet_state_e;

  localparam int DEF_CODE_W    = 6;
  localparam int DEF_WIN_LOG2  = 4;
  localparam int DEF_THR       = 4;
  localparam int DEF_LOCK_WINS = 4;
  localparam int DEF_SETTLE    = 3;
  localparam int DEF_CODE_INIT = 32;

endpackage

// File: rtl/an_io_phdet_sat_cnt.sv
// Saturating up/down delay-code register with a one-cycle change pulse.
module an_io_phdet_sat_cnt
  import an_io_phdet_pkg::*;
#(
  parameter int W    = DEF_CODE_W,
  parameter int INIT = DEF_CODE_INIT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] code_o,
  output logic         upd_o,
  output logic         at_max_o,
  output logic         at_min_o
);

  localparam logic [W-1:0] MAX_V  = '1;
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic [W-1:0] code_q, code_d;
  logic         upd_q, upd_d;

  assign at_max_o = (code_q == MAX_V);
  assign at_min_o = (code_q == '0);
  assign code_o   = code_q;
  assign upd_o    = upd_q;

  // A step into a rail is dropped entirely, so no pulse is raised for it.
  always_comb begin
    code_d = code_q;
    upd_d  = 1'b0;
    if (inc_i && !at_max_o) begin
      code_d = code_q + 1'b1;
      upd_d  = 1'b1;
    end else if (dec_i && !at_min_o) begin
      code_d = code_q - 1'b1;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= INIT_V;
      upd_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      upd_q  <= upd_d;
    end
  end

endmodule

// File: rtl/an_io_phdet_filter.sv
// Majority-vote phase-detector filter driving a saturating delay code.
// Optional code_hold input is enabled with `define AN_IO_PHDET_HOLD_EN.
//
// state     | meaning
// ST_IDLE   | filter disabled, counters and lock cleared, code held
// ST_ACCUM  | collect one phdet_q sample per cycle for WIN cycles
// ST_UPDATE | one-cycle vote decision, code step and lock bookkeeping
// ST_SETTLE | wait SETTLE cycles for the delay line, samples ignored
module an_io_phdet_filter
  import an_io_phdet_pkg::*;
#(
  parameter int CODE_W    = DEF_CODE_W,
  parameter int WIN_LOG2  = DEF_WIN_LOG2,
  parameter int THR       = DEF_THR,
  parameter int LOCK_WINS = DEF_LOCK_WINS,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int CODE_INIT = DEF_CODE_INIT
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
`ifdef AN_IO_PHDET_HOLD_EN
  input  logic              code_hold,
`endif
  input  logic              phdet_q,
  output logic [CODE_W-1:0] dly_code,
  output logic              code_upd,
  output logic              locked
);

  localparam int WIN = 2 ** WIN_LOG2;
  localparam int LW  = (LOCK_WINS < 1) ? 1 : $clog2(LOCK_WINS + 1);
  localparam int SW  = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  localparam logic [WIN_LOG2:0]   UP_TH     = (WIN_LOG2 + 1)'(WIN - THR);
  localparam logic [WIN_LOG2:0]   DN_TH     = (WIN_LOG2 + 1)'(THR);
  localparam logic [WIN_LOG2-1:0] SAMP_LAST = '1;
  localparam logic [LW-1:0]       LOCK_MAX  = LW'(LOCK_WINS);
  localparam logic [SW-1:0]       SETTLE_LD = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  phdet_state_e        state_q, state_d;
  logic [WIN_LOG2-1:0] samp_q, samp_d;
  logic [WIN_LOG2:0]   ones_q, ones_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [LW-1:0]       lock_q, lock_d;
  logic                oob_q, oob_d;
  logic                locked_q, locked_d;

  logic hold_w;
  logic inc, dec, at_max, at_min;
  logic vote_up, vote_dn, in_band, chg;

`ifdef AN_IO_PHDET_HOLD_EN
  assign hold_w = code_hold;
`else
  assign hold_w = 1'b0;
`endif

  assign vote_up = (ones_q >= UP_TH);
  assign vote_dn = !vote_up && (ones_q <= DN_TH);
  assign in_band = !vote_up && !vote_dn;

  an_io_phdet_sat_cnt #(
    .W    (CODE_W),
    .INIT (CODE_INIT)
  ) u_code (
    .clk_i    (clk_in),
    .rst_i    (reset),
    .inc_i    (inc),
    .dec_i    (dec),
    .code_o   (dly_code),
    .upd_o    (code_upd),
    .at_max_o (at_max),
    .at_min_o (at_min)
  );

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    ones_d   = ones_q;
    settle_d = settle_q;
    lock_d   = lock_q;
    oob_d    = oob_q;
    locked_d = locked_q;
    inc      = 1'b0;
    dec      = 1'b0;
    chg      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        ones_d = ones_q + {{WIN_LOG2{1'b0}}, phdet_q};
        samp_d = samp_q + 1'b1;
        if (samp_q == SAMP_LAST) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        inc    = vote_up && !hold_w;
        dec    = vote_dn && !hold_w;
        chg    = (inc && !at_max) || (dec && !at_min);
        samp_d = '0;
        ones_d = '0;
        if (in_band) begin
          oob_d = 1'b0;
          if (lock_q != LOCK_MAX) lock_d = lock_q + 1'b1;
          if (lock_d == LOCK_MAX) locked_d = 1'b1;
        end else begin
          lock_d = '0;
          // oob_q remembers one tolerated out-of-band window while locked.
          if (locked_q) begin
            if (oob_q) begin
              locked_d = 1'b0;
              oob_d    = 1'b0;
            end else begin
              oob_d = 1'b1;
            end
          end
        end
        if (chg && (SETTLE > 0)) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LD;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_ACCUM;
        else                settle_d = settle_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // inc/dec stay as computed so a code step in UPDATE survives enable dropping.
    if (!enable) begin
      state_d  = ST_IDLE;
      samp_d   = '0;
      ones_d   = '0;
      settle_d = '0;
      lock_d   = '0;
      oob_d    = 1'b0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      samp_q   <= '0;
      ones_q   <= '0;
      settle_q <= '0;
      lock_q   <= '0;
      oob_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      ones_q   <= ones_d;
      settle_q <= settle_d;
      lock_q   <= lock_d;
      oob_q    <= oob_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_an_io_phdet_filter.sv
// Scoreboard bench for an_io_phdet_filter (default parameters).
module tb_an_io_phdet_filter;

  logic       clk = 1'b0;
  logic       reset, enable, phdet;
  logic [5:0] dly_code;
  logic       code_upd, locked;
`ifdef AN_IO_PHDET_HOLD_EN
  logic       code_hold = 1'b0;
`endif

  always #5 clk = ~clk;

  an_io_phdet_filter dut (
    .clk_in   (clk),
    .reset    (reset),
    .enable   (enable),
`ifdef AN_IO_PHDET_HOLD_EN
    .code_hold(code_hold),
`endif
    .phdet_q  (phdet),
    .dly_code (dly_code),
    .code_upd (code_upd),
    .locked   (locked)
  );

  typedef struct packed {
    logic [5:0] code;
    logic       upd;
    logic       lck;
  } exp_t;

  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  int   m_code   = 32;
  int   m_lock   = 0;
  bit   m_locked = 1'b0;
  bit   m_oob    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       prev_upd  = 1'b0;
  logic [5:0] prev_code = 6'd32;

  always @(negedge clk) begin
    if (!reset) begin
      if (code_upd) chk("upd_twice", 32'(prev_upd), 32'd0);
      if (dly_code != prev_code) chk("upd_with_chg", 32'(code_upd), 32'd1);
    end
    prev_upd  = code_upd;
    prev_code = dly_code;
  end

  // Drives one full window from the first ACCUM sample; leaves the FSM ready
  // to take the next window's first sample on the following edge.
  task automatic window(input logic [15:0] pat, input bit hold, input bit drop_en,
                        input string tag);
    int   ones;
    bit   up, dn, chg;
    int   pre;
    exp_t e;
    ones = $countones(pat);
    up   = (ones >= 12);
    dn   = !up && (ones <= 4);
    pre  = m_code;
    chg  = 1'b0;
    if (!hold) begin
      if (up && m_code < 63) begin
        m_code++;
        chg = 1'b1;
      end else if (dn && m_code > 0) begin
        m_code--;
        chg = 1'b1;
      end
    end
    if (!up && !dn) begin
      m_oob = 1'b0;
      if (m_lock < 4) m_lock++;
      if (m_lock == 4) m_locked = 1'b1;
    end else begin
      m_lock = 0;
      if (m_locked) begin
        if (m_oob) begin
          m_locked = 1'b0;
          m_oob    = 1'b0;
        end else begin
          m_oob = 1'b1;
        end
      end
    end
    if (drop_en) begin
      m_lock   = 0;
      m_oob    = 1'b0;
      m_locked = 1'b0;
    end
    sb_q.push_back('{code: 6'(m_code), upd: chg, lck: m_locked});

    for (int i = 0; i < 16; i++) begin
      phdet = pat[i];
`ifdef AN_IO_PHDET_HOLD_EN
      code_hold = hold;
`endif
      tick();
    end
    phdet = 1'b0;
    chk({tag, "_pre_upd"}, 32'(code_upd), 32'd0);
    chk({tag, "_pre_code"}, 32'(dly_code), 32'(pre));
    if (drop_en) enable = 1'b0;
    tick();
    e = sb_q.pop_front();
    chk({tag, "_code"}, 32'(dly_code), 32'(e.code));
    chk({tag, "_upd"}, 32'(code_upd), 32'(e.upd));
    chk({tag, "_locked"}, 32'(locked), 32'(e.lck));
    if (drop_en) begin
      enable = 1'b1;
      tick();
    end else if (chg) begin
      phdet = 1'b1;
      tick();
      chk({tag, "_settle_upd"}, 32'(code_upd), 32'd0);
      tick();
      phdet = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    phdet  = 1'b0;
    tick();
    phdet = 1'b1;
    tick();
    chk("rst_code", 32'(dly_code), 32'd32);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_upd", 32'(code_upd), 32'd0);
    phdet  = 1'b0;
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    chk("post_rst_code", 32'(dly_code), 32'd32);

    enable = 1'b1;
    tick();
    window(16'hFFFF, 1'b0, 1'b0, "late");
    window(16'hFFF0, 1'b0, 1'b0, "edge12");

    while (m_code < 62) window(16'hFFFF, 1'b0, 1'b0, "ramp_up");
    window(16'hFFFF, 1'b0, 1'b0, "sat_hi");
    window(16'hFFFF, 1'b0, 1'b0, "sat_hi_again");
    while (m_code > 1) window(16'h0000, 1'b0, 1'b0, "ramp_dn");
    window(16'h0000, 1'b0, 1'b0, "sat_lo");
    window(16'h0000, 1'b0, 1'b0, "sat_lo_again");

    while (m_code < 10) window(16'hFFFF, 1'b0, 1'b0, "ramp_mid");
    window(16'h000F, 1'b0, 1'b0, "edge4");
    window(16'h001F, 1'b0, 1'b0, "edge5");
    window(16'h07FF, 1'b0, 1'b0, "edge11");
    window(16'hFFFF, 1'b0, 1'b0, "clr_lock");

    for (int k = 0; k < 4; k++) window(16'h5555, 1'b0, 1'b0, "lock");
    window(16'h0000, 1'b0, 1'b0, "oob1");
    window(16'h5555, 1'b0, 1'b0, "inb");
    window(16'h0000, 1'b0, 1'b0, "oob1b");
    window(16'h0000, 1'b0, 1'b0, "oob2");

    for (int k = 0; k < 4; k++) window(16'h5555, 1'b0, 1'b0, "relock");
    for (int k = 0; k < 10; k++) begin
      phdet = 1'b1;
      tick();
    end
    enable = 1'b0;
    tick();
    chk("abort_locked", 32'(locked), 32'd0);
    m_lock   = 0;
    m_oob    = 1'b0;
    m_locked = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    window(16'h00FF, 1'b0, 1'b0, "abort");

    window(16'hFFFF, 1'b0, 1'b1, "drop_upd");

`ifdef AN_IO_PHDET_HOLD_EN
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    m_code   = 32;
    m_lock   = 0;
    m_oob    = 1'b0;
    m_locked = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    window(16'hFFFF, 1'b1, 1'b0, "hold");
    window(16'hFFFF, 1'b1, 1'b0, "hold2");
    window(16'hFFFF, 1'b0, 1'b0, "release");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
